// File: rtl/id_pkg.sv
// Shared definitions for the pipelined DLX decode stage: control-bundle bit map,
// FSM and ALU encodings, and the opcode -> control decode used by the stage.
package id_pkg;

  localparam int CTRL_W     = 20;

  localparam int PCTOREG    = 0;
  localparam int REGTOPC    = 1;
  localparam int JUMP       = 2;
  localparam int BRANCH     = 3;
  localparam int BRZERO     = 4;
  localparam int RTYPE      = 5;
  localparam int REGWRITE   = 6;
  localparam int MEMTOREG   = 7;
  localparam int MEMWRITE   = 8;
  localparam int LOADSIGN   = 9;
  localparam int MUL        = 10;
  localparam int EXTOP      = 11;
  localparam int LHIOP      = 12;
  localparam int JUMPNONREG = 13;
  localparam int DSIZE_LO   = 14;
  localparam int ALUCTRL_LO = 16;

  localparam logic [1:0] DS_BYTE = 2'd0;
  localparam logic [1:0] DS_HALF = 2'd1;
  localparam logic [1:0] DS_WORD = 2'd2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } id_state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2,  ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,  ALU_SLL = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7,
    ALU_SEQ = 4'd8,  ALU_SNE = 4'd9,  ALU_SLT = 4'd10, ALU_SGT = 4'd11,
    ALU_SLE = 4'd12, ALU_SGE = 4'd13
  } alu_op_e;

  function automatic alu_op_e alu_from_func(input logic [5:0] fn);
    alu_op_e a;
    case (fn)
      6'h20, 6'h21: a = ALU_ADD;
      6'h22, 6'h23: a = ALU_SUB;
      6'h24:        a = ALU_AND;
      6'h25:        a = ALU_OR;
      6'h26:        a = ALU_XOR;
      6'h04:        a = ALU_SLL;
      6'h06:        a = ALU_SRL;
      6'h07:        a = ALU_SRA;
      6'h28:        a = ALU_SEQ;
      6'h29:        a = ALU_SNE;
      6'h2A:        a = ALU_SLT;
      6'h2B:        a = ALU_SGT;
      6'h2C:        a = ALU_SLE;
      6'h2D:        a = ALU_SGE;
      default:      a = ALU_ADD;
    endcase
    return a;
  endfunction

  // Immediate set/shift opcodes share their low nibble with the matching R-type func.
  function automatic logic [CTRL_W-1:0] ctrl_decode(input logic [5:0] op, input logic [5:0] fn);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (op)
      6'h00: begin
        c[RTYPE] = 1'b1; c[REGWRITE] = 1'b1;
        c[ALUCTRL_LO +: 4] = alu_from_func(fn);
      end
      6'h01: begin
        c[RTYPE] = 1'b1; c[REGWRITE] = 1'b1; c[MUL] = (fn == 6'h0E);
      end
      6'h02: begin
        c[JUMP] = 1'b1; c[JUMPNONREG] = 1'b1;
      end
      6'h03: begin
        c[JUMP] = 1'b1; c[JUMPNONREG] = 1'b1; c[PCTOREG] = 1'b1; c[REGWRITE] = 1'b1;
      end
      6'h04: begin
        c[BRANCH] = 1'b1; c[BRZERO] = 1'b1; c[EXTOP] = 1'b1;
      end
      6'h05: begin
        c[BRANCH] = 1'b1; c[EXTOP] = 1'b1;
      end
      6'h08, 6'h0A: begin
        c[REGWRITE] = 1'b1; c[EXTOP] = 1'b1;
        c[ALUCTRL_LO +: 4] = op[1] ? ALU_SUB : ALU_ADD;
      end
      6'h09, 6'h0B: begin
        c[REGWRITE] = 1'b1;
        c[ALUCTRL_LO +: 4] = op[1] ? ALU_SUB : ALU_ADD;
      end
      6'h0C: begin c[REGWRITE] = 1'b1; c[ALUCTRL_LO +: 4] = ALU_AND; end
      6'h0D: begin c[REGWRITE] = 1'b1; c[ALUCTRL_LO +: 4] = ALU_OR;  end
      6'h0E: begin c[REGWRITE] = 1'b1; c[ALUCTRL_LO +: 4] = ALU_XOR; end
      6'h0F: begin
        c[REGWRITE] = 1'b1; c[LHIOP] = 1'b1; c[ALUCTRL_LO +: 4] = ALU_SLL;
      end
      6'h12: begin
        c[JUMP] = 1'b1; c[REGTOPC] = 1'b1;
      end
      6'h13: begin
        c[JUMP] = 1'b1; c[REGTOPC] = 1'b1; c[PCTOREG] = 1'b1; c[REGWRITE] = 1'b1;
      end
      6'h14, 6'h16, 6'h17: begin
        c[REGWRITE] = 1'b1; c[ALUCTRL_LO +: 4] = alu_from_func({2'b00, op[3:0]});
      end
      6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: begin
        c[REGWRITE] = 1'b1; c[EXTOP] = 1'b1;
        c[ALUCTRL_LO +: 4] = alu_from_func({2'b10, op[3:0]});
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        c[REGWRITE] = 1'b1; c[MEMTOREG] = 1'b1; c[EXTOP] = 1'b1;
        c[LOADSIGN] = ~op[2];
        c[DSIZE_LO +: 2] = (op[1:0] == 2'b11) ? DS_WORD : (op[0] ? DS_HALF : DS_BYTE);
      end
      6'h28, 6'h29, 6'h2B: begin
        c[MEMWRITE] = 1'b1; c[EXTOP] = 1'b1;
        c[DSIZE_LO +: 2] = (op[1:0] == 2'b11) ? DS_WORD : (op[0] ? DS_HALF : DS_BYTE);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_pipelined_hazard.sv
// Load-use hazard detector: stalls ID when the EX-stage load writes a register
// this instruction reads, unless ID is being flushed or the stage is not running.
module id_hazard_unit
  import id_pkg::*;
#(
  parameter int RADDR = 5
) (
  input  logic             i_valid,
  input  logic             i_ex_load,
  input  logic [RADDR-1:0] i_ex_dest,
  input  logic [RADDR-1:0] i_r1,
  input  logic [RADDR-1:0] i_r2,
  input  logic             i_use_b,
  input  logic             i_flush,
  input  logic             i_run,
  output logic             o_stall
);

  logic w_hit_a;
  logic w_hit_b;
  logic w_hazard;

  assign w_hit_a  = (i_ex_dest == i_r1);
  assign w_hit_b  = i_use_b & (i_ex_dest == i_r2);
  assign w_hazard = i_valid & i_ex_load & (i_ex_dest != {RADDR{1'b0}}) & (w_hit_a | w_hit_b);
  assign o_stall  = w_hazard & ~i_flush & i_run;

endmodule

// File: rtl/id_stage_pipelined.sv
// DLX decode stage with an ID/EX register, load-use stall, flush and a
// trap drain/halt sequencer.
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int              SIZE         = 32,
  parameter int              RADDR        = 5,
  parameter int              LINK_REG     = 31,
  parameter logic [SIZE-1:0] TRAP_WORD    = 32'h44000300,
  parameter int              DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [SIZE-1:0]   instruction_in,
  input  logic [SIZE-1:0]   nextPC_in,
  input  logic [SIZE-1:0]   busA_in,
  input  logic [SIZE-1:0]   busB_in,
  input  logic              flush,
  input  logic              ex_load,
  input  logic [RADDR-1:0]  ex_destReg,
  output logic              stall_out,
  output logic [RADDR-1:0]  r1_out,
  output logic [RADDR-1:0]  r2_out,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [SIZE-1:0]   nextPC_out,
  output logic [SIZE-1:0]   busA_out,
  output logic [SIZE-1:0]   busB_out,
  output logic [SIZE-1:0]   memVal_out,
  output logic [15:0]       imm16_out,
  output logic [25:0]       imm26_out,
  output logic [RADDR-1:0]  destReg_out,
  output logic              trap_out
);

  localparam logic [SIZE-1:0]  LHI_SHAMT  = SIZE'(16);
  localparam logic [RADDR-1:0] LINK_ADDR  = RADDR'(LINK_REG);
  localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  logic [CTRL_W-1:0] w_ctrl;
  logic [RADDR-1:0]  w_r1, w_r2, w_rd, w_dest;
  logic [15:0]       w_imm16;
  logic [25:0]       w_imm26;
  logic [SIZE-1:0]   w_ext, w_busA, w_busB;
  logic              w_trap_accept, w_bubble, w_run;

  id_state_e r_state, w_state_next;
  logic [3:0] r_cnt, w_cnt_next;

  logic              r_valid, r_trap;
  logic [CTRL_W-1:0] r_ctrl;
  logic [SIZE-1:0]   r_pc, r_busA, r_busB, r_memVal;
  logic [15:0]       r_imm16;
  logic [25:0]       r_imm26;
  logic [RADDR-1:0]  r_dest;

  assign w_ctrl  = ctrl_decode(instruction_in[31:26], instruction_in[5:0]);
  assign w_r1    = instruction_in[25:21];
  assign w_r2    = instruction_in[20:16];
  assign w_rd    = instruction_in[15:11];
  assign w_imm16 = instruction_in[15:0];
  assign w_imm26 = instruction_in[25:0];

  assign w_ext  = w_ctrl[EXTOP] ? {{(SIZE-16){w_imm16[15]}}, w_imm16} : {{(SIZE-16){1'b0}}, w_imm16};
  assign w_busA = w_ctrl[LHIOP] ? {{(SIZE-16){1'b0}}, w_imm16} : busA_in;
  assign w_busB = w_ctrl[RTYPE] ? busB_in : (w_ctrl[LHIOP] ? LHI_SHAMT : w_ext);
  assign w_dest = w_ctrl[PCTOREG] ? LINK_ADDR : (w_ctrl[RTYPE] ? w_rd : w_r2);

  assign r1_out = w_r1;
  assign r2_out = w_r2;
  assign w_run  = (r_state == RUN);

  id_hazard_unit #(.RADDR(RADDR)) u_hazard (
    .i_valid   (valid_in),
    .i_ex_load (ex_load),
    .i_ex_dest (ex_destReg),
    .i_r1      (w_r1),
    .i_r2      (w_r2),
    .i_use_b   (w_ctrl[RTYPE] | w_ctrl[MEMWRITE]),
    .i_flush   (flush),
    .i_run     (w_run),
    .o_stall   (stall_out)
  );

  // A trap is consumed as a bubble; flush and stall both keep it from being taken.
  assign w_trap_accept = w_run & valid_in & ~flush & ~stall_out & (instruction_in == TRAP_WORD);
  assign w_bubble      = flush | stall_out | ~w_run | w_trap_accept;

  // Next-state logic for the trap drain/halt sequencer.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_trap_accept) begin
          w_state_next = DRAIN;
          w_cnt_next   = DRAIN_LOAD;
        end else begin
          w_state_next = RUN;
        end
      end
      DRAIN: begin
        if (r_cnt == 4'd0) begin
          w_state_next = HALTED;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      HALTED:  w_state_next = HALTED;
      default: w_state_next = RUN;
    endcase
  end

  // Sequencer state, drain counter and halt flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
      r_trap  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_trap  <= (w_state_next == HALTED);
    end
  end

  // ID/EX register; bubbles clear only valid and control, data may stay stale.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_pc     <= '0;
      r_busA   <= '0;
      r_busB   <= '0;
      r_memVal <= '0;
      r_imm16  <= 16'd0;
      r_imm26  <= 26'd0;
      r_dest   <= '0;
    end else if (w_bubble) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid  <= valid_in;
      r_ctrl   <= w_ctrl;
      r_pc     <= nextPC_in;
      r_busA   <= w_busA;
      r_busB   <= w_busB;
      r_memVal <= busB_in;
      r_imm16  <= w_imm16;
      r_imm26  <= w_imm26;
      r_dest   <= w_dest;
    end
  end

  assign valid_out   = r_valid;
  assign ctrl_out    = r_ctrl;
  assign nextPC_out  = r_pc;
  assign busA_out    = r_busA;
  assign busB_out    = r_busB;
  assign memVal_out  = r_memVal;
  assign imm16_out   = r_imm16;
  assign imm26_out   = r_imm26;
  assign destReg_out = r_dest;
  assign trap_out    = r_trap;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed scoreboard bench for id_stage_pipelined: expectations are queued as
// each instruction is driven and compared one edge later.
module tb_id_stage_pipelined;
  import id_pkg::*;

  logic              clk = 1'b0;
  logic              reset, valid_in, flush, ex_load;
  logic [31:0]       instruction_in, nextPC_in, busA_in, busB_in;
  logic [4:0]        ex_destReg;
  logic              stall_out, valid_out, trap_out;
  logic [4:0]        r1_out, r2_out, destReg_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [31:0]       nextPC_out, busA_out, busB_out, memVal_out;
  logic [15:0]       imm16_out;
  logic [25:0]       imm26_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic              valid;
    logic              trap;
    logic [CTRL_W-1:0] cmask;
    logic [CTRL_W-1:0] cval;
    logic              chk;
    logic [31:0]       a, b, pc, mem;
    logic [15:0]       i16;
    logic [25:0]       i26;
    logic [4:0]        dest;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] I_ADDI = 32'h2023FFFF;  // addi r3,r1,#-1
  localparam logic [31:0] I_LHI  = 32'h3C041234;  // lhi  r4,#0x1234
  localparam logic [31:0] I_ADD  = 32'h00A73020;  // add  r6,r5,r7
  localparam logic [31:0] I_SW   = 32'hAD280004;  // sw   4(r9),r8
  localparam logic [31:0] I_JAL  = 32'h0C000100;  // jal  +0x100
  localparam logic [31:0] I_TRAP = 32'h44000300;

  id_stage_pipelined dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .instruction_in(instruction_in),
    .nextPC_in(nextPC_in), .busA_in(busA_in), .busB_in(busB_in), .flush(flush),
    .ex_load(ex_load), .ex_destReg(ex_destReg), .stall_out(stall_out),
    .r1_out(r1_out), .r2_out(r2_out), .valid_out(valid_out), .ctrl_out(ctrl_out),
    .nextPC_out(nextPC_out), .busA_out(busA_out), .busB_out(busB_out),
    .memVal_out(memVal_out), .imm16_out(imm16_out), .imm26_out(imm26_out),
    .destReg_out(destReg_out), .trap_out(trap_out)
  );

  always #5 clk = ~clk;

  function automatic logic [CTRL_W-1:0] bm(input int i);
    logic [CTRL_W-1:0] one;
    one = {{(CTRL_W-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t bub(input logic trap);
    exp_t e;
    e = '{valid: 1'b0, trap: trap, cmask: '1, cval: '0, chk: 1'b0,
          a: 32'd0, b: 32'd0, pc: 32'd0, mem: 32'd0, i16: 16'd0, i26: 26'd0, dest: 5'd0};
    return e;
  endfunction

  function automatic exp_t zero_state();
    exp_t e;
    e = bub(1'b0);
    e.chk = 1'b1;
    return e;
  endfunction

  function automatic exp_t live(input logic [CTRL_W-1:0] m, input logic [CTRL_W-1:0] v,
                                input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    exp_t e;
    logic [31:0] ins;
    ins = instruction_in;
    e = '{valid: 1'b1, trap: 1'b0, cmask: m, cval: v, chk: 1'b1, a: a, b: b,
          pc: nextPC_in, mem: busB_in, i16: ins[15:0], i26: ins[25:0], dest: d};
    return e;
  endfunction

  task automatic drv(input logic [31:0] ins, input logic v);
    instruction_in = ins;
    valid_in       = v;
    nextPC_in      = nextPC_in + 32'd4;
    busA_in        = $urandom;
    busB_in        = $urandom;
  endtask

  task automatic step(input exp_t e);
    exp_t g;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("valid_out", {31'd0, valid_out}, {31'd0, g.valid});
    check("trap_out", {31'd0, trap_out}, {31'd0, g.trap});
    check("ctrl_out", {12'd0, ctrl_out & g.cmask}, {12'd0, g.cval});
    if (g.chk) begin
      check("busA_out", busA_out, g.a);
      check("busB_out", busB_out, g.b);
      check("nextPC_out", nextPC_out, g.pc);
      check("memVal_out", memVal_out, g.mem);
      check("imm16_out", {16'd0, imm16_out}, {16'd0, g.i16});
      check("imm26_out", {6'd0, imm26_out}, {6'd0, g.i26});
      check("destReg_out", {27'd0, destReg_out}, {27'd0, g.dest});
    end
  endtask

  logic [CTRL_W-1:0] m_addi, v_addi, m_lhi, v_lhi, m_add, v_add, m_sw, v_sw, m_jal;

  initial begin
    m_addi = bm(REGWRITE) | bm(EXTOP) | bm(MEMWRITE) | bm(RTYPE);
    v_addi = bm(REGWRITE) | bm(EXTOP);
    m_lhi  = bm(LHIOP) | bm(REGWRITE) | bm(RTYPE);
    v_lhi  = bm(LHIOP) | bm(REGWRITE);
    m_add  = bm(RTYPE) | bm(REGWRITE) | bm(MEMWRITE);
    v_add  = bm(RTYPE) | bm(REGWRITE);
    m_sw   = bm(MEMWRITE) | bm(REGWRITE);
    v_sw   = bm(MEMWRITE);
    m_jal  = bm(PCTOREG) | bm(REGWRITE) | bm(JUMP) | bm(JUMPNONREG);

    reset = 1'b0; valid_in = 1'b0; flush = 1'b0; ex_load = 1'b0; ex_destReg = 5'd0;
    instruction_in = 32'd0; nextPC_in = 32'h100; busA_in = 32'd0; busB_in = 32'd0;
    step(zero_state());
    step(zero_state());
    reset = 1'b1;

    // T1: addi with sign extension; an EX load to r3 is not a hazard (r2 unused)
    drv(I_ADDI, 1'b1);
    ex_load = 1'b1; ex_destReg = 5'd3;
    #1 check("r1_out", {27'd0, r1_out}, 32'd1);
    check("r2_out", {27'd0, r2_out}, 32'd3);
    check("stall_addi_r2", {31'd0, stall_out}, 32'd0);
    step(live(m_addi, v_addi, busA_in, 32'hFFFFFFFF, 5'd3));
    ex_load = 1'b0;

    // T2: lhi
    drv(I_LHI, 1'b1);
    step(live(m_lhi, v_lhi, 32'h00001234, 32'd16, 5'd4));

    // T3: load-use on r1, then on r2, then release
    drv(I_ADD, 1'b1);
    ex_load = 1'b1; ex_destReg = 5'd5;
    #1 check("stall_r1", {31'd0, stall_out}, 32'd1);
    step(bub(1'b0));
    check("stall_hold", {31'd0, stall_out}, 32'd1);
    ex_destReg = 5'd7;
    #1 check("stall_r2", {31'd0, stall_out}, 32'd1);
    step(bub(1'b0));
    valid_in = 1'b0;
    #1 check("stall_invalid", {31'd0, stall_out}, 32'd0);
    step('{valid: 1'b0, trap: 1'b0, cmask: '0, cval: '0, chk: 1'b0,
           a: 32'd0, b: 32'd0, pc: 32'd0, mem: 32'd0, i16: 16'd0, i26: 26'd0, dest: 5'd0});
    valid_in = 1'b1; ex_load = 1'b0;
    #1 check("stall_release", {31'd0, stall_out}, 32'd0);
    step(live(m_add, v_add, busA_in, busB_in, 5'd6));

    // T4: store hazard, then flush overrides it
    drv(I_SW, 1'b1);
    ex_load = 1'b1; ex_destReg = 5'd8;
    #1 check("stall_store", {31'd0, stall_out}, 32'd1);
    flush = 1'b1;
    #1 check("stall_flush", {31'd0, stall_out}, 32'd0);
    step(bub(1'b0));
    flush = 1'b0; ex_load = 1'b0;
    step(live(m_sw, v_sw, busA_in, 32'd4, 5'd8));

    // T5: jal, trap squashed by flush, then a real trap drains and halts
    drv(I_JAL, 1'b1);
    step(live(m_jal, m_jal, busA_in, 32'h00000100, 5'd31));
    drv(I_TRAP, 1'b1);
    flush = 1'b1;
    step(bub(1'b0));
    flush = 1'b0;
    drv(I_ADDI, 1'b1);
    step(live(m_addi, v_addi, busA_in, 32'hFFFFFFFF, 5'd3));
    drv(I_TRAP, 1'b1);
    step(bub(1'b0));
    drv(I_ADDI, 1'b1);
    ex_load = 1'b1; ex_destReg = 5'd1;
    #1 check("stall_drain", {31'd0, stall_out}, 32'd0);
    step(bub(1'b0));
    ex_load = 1'b0;
    step(bub(1'b0));
    step(bub(1'b1));
    drv(I_LHI, 1'b1);
    step(bub(1'b1));
    reset = 1'b0;
    step(zero_state());
    reset = 1'b1;
    drv(I_LHI, 1'b1);
    step(live(m_lhi, v_lhi, 32'h00001234, 32'd16, 5'd4));

    // T6: reset pulse mid-stream, then reset mid-drain
    drv(I_ADDI, 1'b1);
    step(live(m_addi, v_addi, busA_in, 32'hFFFFFFFF, 5'd3));
    drv(I_LHI, 1'b1);
    reset = 1'b0;
    step(zero_state());
    reset = 1'b1;
    step(live(m_lhi, v_lhi, 32'h00001234, 32'd16, 5'd4));
    drv(I_TRAP, 1'b1);
    step(bub(1'b0));
    step(bub(1'b0));
    reset = 1'b0;
    step(zero_state());
    reset = 1'b1;
    drv(I_ADD, 1'b1);
    step(live(m_add, v_add, busA_in, busB_in, 5'd6));
    step(live(m_add, v_add, busA_in, busB_in, 5'd6));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
